// File: rtl/button_pkg.sv
// Shared types, defaults and width helper for the push-button debouncer.
package button_pkg;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_LONG_CYCLES     = 1000000;

  typedef enum logic [1:0] {
    StStableLow,
    StCheckHigh,
    StStableHigh,
    StCheckLow
  } state_e;

  // Bits needed to hold the values 0..max_val without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_sync.sv
// Multi-flop synchronizer bringing the raw button level into the system1000 domain.
module button_sync
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic system1000,
  input  logic system1000_rst,
  input  logic btn_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] stages_q;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign sync_o = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button and emits press, release and long-press pulses.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic system1000,
  input  logic system1000_rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DebW  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = cnt_width(LONG_CYCLES);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);

  logic             s;
  state_e           state_q;
  logic [DebW-1:0]  deb_q;
  logic [HoldW-1:0] hold_q;

  button_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .system1000    (system1000),
    .system1000_rst(system1000_rst),
    .btn_i         (btn_i),
    .sync_o        (s)
  );

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q   <= StStableLow;
      deb_q     <= '0;
      hold_q    <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      // Hold time keeps running through CHECK_LOW; it only stops at saturation.
      long_o    <= level_o && (hold_q == HoldLast);
      if (level_o && (hold_q != HoldMax)) begin
        hold_q <= hold_q + 1'b1;
      end

      unique case (state_q)
        StStableLow: begin
          if (s) begin
            state_q <= StCheckHigh;
            deb_q   <= DebW'(1);
          end
        end
        StCheckHigh: begin
          if (!s) begin
            state_q <= StStableLow;
          end else if (deb_q == DebLast) begin
            state_q <= StStableHigh;
            level_o <= 1'b1;
            press_o <= 1'b1;
            hold_q  <= '0;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        StStableHigh: begin
          if (!s) begin
            state_q <= StCheckLow;
            deb_q   <= DebW'(1);
          end
        end
        StCheckLow: begin
          if (s) begin
            state_q <= StStableHigh;
          end else if (deb_q == DebLast) begin
            state_q   <= StStableLow;
            level_o   <= 1'b0;
            release_o <= 1'b1;
            hold_q    <= '0;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        default: state_q <= StStableLow;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: vector table, directed corner sequences and random runs vs a run-length model.
module tb_button_debouncer;
  import button_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic level, press, rel, lng;

  button_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .btn_i         (btn),
    .level_o       (level),
    .press_o       (press),
    .release_o     (rel),
    .long_o        (lng)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: synchronizer as a delay queue, debounce as a run length of
  // samples disagreeing with the accepted level, hold time as edges since press.
  bit     m_q[$];
  bit     m_level, m_press, m_rel, m_long;
  int     m_run;
  longint m_edge = 0;
  longint m_press_edge = -1000;

  typedef struct {
    bit rst;
    bit btn;
    bit level;
    bit press;
    bit rel;
    bit lng;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add(input bit r, input bit b, input bit l, input bit p, input bit rl,
                              input bit g);
    vec_t v;
    v.rst = r; v.btn = b; v.level = l; v.press = p; v.rel = rl; v.lng = g;
    tbl.push_back(v);
  endfunction

  task automatic model_edge(input bit r, input bit b);
    bit s;
    bit was_high;
    m_edge++;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (r) begin
      m_q = {};
      repeat (SYNC) m_q.push_back(1'b0);
      m_level = 1'b0;
      m_run   = 0;
      m_press_edge = -1000;
    end else begin
      s = m_q[SYNC-1];
      m_q.push_front(b);
      void'(m_q.pop_back());
      was_high = m_level;
      m_run = (s != m_level) ? m_run + 1 : 0;
      if (m_run == int'(DEB)) begin
        m_level = !m_level;
        m_run   = 0;
        if (m_level) begin
          m_press      = 1'b1;
          m_press_edge = m_edge;
        end else begin
          m_rel = 1'b1;
        end
      end
      if (was_high && (m_edge - m_press_edge == longint'(LONG))) m_long = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit b);
    @(negedge clk);
    rst = r;
    btn = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    chk("model_level", level, m_level);
    chk("model_press", press, m_press);
    chk("model_release", rel, m_rel);
    chk("model_long", lng, m_long);
    chk("press_release_exclusive", press & rel, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_v({tag, "_state"}, 32'(dut.state_q), 32'(StStableLow));
    chk_v({tag, "_deb"}, 32'(dut.deb_q), 32'd0);
    chk_v({tag, "_hold"}, 32'(dut.hold_q), 32'd0);
    chk_v({tag, "_sync"}, 32'(dut.u_sync.stages_q), 32'd0);
  endtask

  initial begin
    int long_cnt;
    int long_at;
    int rel_cnt;

    model_edge(1'b1, 1'b0);

    // Reset with button held, accepted press, then clean release before long time.
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    repeat (5) add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0);
    repeat (5) add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].btn);
      chk("tbl_level", level, tbl[i].level);
      chk("tbl_press", press, tbl[i].press);
      chk("tbl_release", rel, tbl[i].rel);
      chk("tbl_long", lng, tbl[i].lng);
    end

    // Short bounce rejected, then a clean press accepted.
    step(1'b1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      step(1'b0, j < 3);
      chk("bounce_level", level, 1'b0);
      chk("bounce_press", press, 1'b0);
      chk("bounce_release", rel, 1'b0);
    end
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 1'b1);
      chk("after_bounce_press", press, j == 6);
      chk("after_bounce_level", level, j == 6);
    end

    // Held press with a short low glitch: one long pulse at press+10, no release.
    long_cnt = 0; long_at = -1; rel_cnt = 0;
    for (int j = 1; j <= 25; j++) begin
      step(1'b0, !(j == 5 || j == 6));
      if (lng) begin long_cnt++; long_at = j; end
      if (rel) rel_cnt++;
    end
    chk_v("glitch_long_count", long_cnt, 1);
    chk_v("glitch_long_edge", long_at, 10);
    chk_v("glitch_release_count", rel_cnt, 0);

    // Release, then a short press that releases before long time.
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 1'b0);
      chk("release_edge", rel, j == 6);
    end
    for (int j = 1; j <= 6; j++) step(1'b0, 1'b1);
    chk("short_press", press, 1'b1);
    long_cnt = 0;
    for (int j = 1; j <= 9; j++) begin
      step(1'b0, j <= 3);
      if (lng) long_cnt++;
      if (j > 3) chk("short_release", rel, j == 9);
    end
    chk_v("short_no_long", long_cnt, 0);

    // Immediate re-press counts hold time from the new press.
    for (int j = 1; j <= 6; j++) step(1'b0, 1'b1);
    chk("repress", press, 1'b1);
    for (int j = 1; j <= 12; j++) begin
      step(1'b0, 1'b1);
      chk("repress_long", lng, j == 10);
    end

    // Reset in CHECK_HIGH, then reset while the level is high.
    for (int j = 1; j <= 6; j++) step(1'b0, 1'b0);
    for (int j = 1; j <= 4; j++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_chk_level", level, 1'b0);
    chk("rst_chk_press", press, 1'b0);
    chk_reset_state("rst_chk");
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 1'b1);
      chk("post_rst_press", press, j == 6);
    end
    for (int j = 1; j <= 3; j++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_high_level", level, 1'b0);
    chk("rst_high_release", rel, 1'b0);
    chk_reset_state("rst_high");
    for (int j = 1; j <= 3; j++) begin
      step(1'b0, 1'b0);
      chk("rst_high_no_release", rel, 1'b0);
    end

    // Random runs of held levels with occasional resets.
    step(1'b1, 1'b0);
    for (int n = 0; n < 300; n++) begin
      int unsigned len;
      bit b;
      len = $urandom_range(1, 14);
      b   = 1'($urandom_range(0, 1));
      for (int k = 0; k < int'(len); k++) begin
        step($urandom_range(0, 199) == 0, b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on the raw input (legal >= 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000, consecutive stable synchronized samples needed to accept a level change (legal >= 2).
REQ-003 The block SHALL have parameter LONG_CYCLES, default 1000000, cycles the debounced level must stay high before a long-press event (legal >= 1).
REQ-004 system1000  input  1  sole clock; all state updates on its rising edge.
REQ-005 system1000_rst  input  1  reset, synchronous, active-high.
REQ-006 btn_i  input  1  raw push-button level, asynchronous to system1000, may bounce.
REQ-007 level_o  output  1  debounced button level.
REQ-008 press_o  output  1  one-cycle pulse on an accepted 0->1 level change.
REQ-009 release_o  output  1  one-cycle pulse on an accepted 1->0 level change.
REQ-010 long_o  output  1  one-cycle pulse once per press after LONG_CYCLES of held level.

Function
REQ-011 btn_i SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized sample s, and no logic other than the chain SHALL read btn_i.
REQ-012 The FSM SHALL have states STABLE_LOW, CHECK_HIGH, STABLE_HIGH and CHECK_LOW.
REQ-013 STABLE_LOW with s=1 SHALL go to CHECK_HIGH with the debounce counter set to 1; otherwise it stays.
REQ-014 CHECK_HIGH with s=0 SHALL return to STABLE_LOW (bounce rejected, no output change).
REQ-015 CHECK_HIGH with s=1 and counter=DEBOUNCE_CYCLES-1 SHALL go to STABLE_HIGH and set level_o=1 and press_o=1 on that edge; otherwise the counter increments.
REQ-016 STABLE_HIGH and CHECK_LOW SHALL mirror REQ-013 to REQ-015 with s inverted; acceptance SHALL set level_o=0 and release_o=1.
REQ-017 Latency: a clean btn_i change SHALL appear on level_o at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge counting the first edge that samples the new value; the press_o/release_o pulse SHALL coincide with that edge.
REQ-018 press_o, release_o and long_o SHALL each be high for exactly one cycle, and press_o and release_o SHALL never be high in the same cycle.
REQ-019 The hold counter SHALL clear on the press_o edge and increment every cycle while level_o=1, including cycles spent in CHECK_LOW.
REQ-020 long_o SHALL pulse on the LONG_CYCLES-th edge after the press_o edge, then the hold counter SHALL saturate with no further long_o until the next press.
REQ-021 A rejected bounce in CHECK_LOW SHALL neither clear nor pause the hold counter.
REQ-022 The release_o edge SHALL clear the hold counter; release before LONG_CYCLES SHALL produce no long_o.
REQ-023 The debounce counter SHALL be clog2(DEBOUNCE_CYCLES+1) bits and the hold counter clog2(LONG_CYCLES+1) bits, unsigned, with no wrap-around.

Reset
REQ-024 system1000_rst=1 SHALL, on the next edge, clear all synchronizer flops, set the FSM to STABLE_LOW, and clear both counters and all outputs.
REQ-025 Reset SHALL take priority over every transition, including mid-CHECK_HIGH/CHECK_LOW and while level_o=1.
REQ-026 Reset while level_o=1 SHALL produce no release_o pulse.

Structure
REQ-027 The FSM state enumeration, the clog2 width helper and the parameter defaults SHALL live in the shared package button_pkg.
REQ-028 The synchronizer chain SHALL be the separate sub-module button_sync, parameterized by SYNC_STAGES, with reset clearing all its stages.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-029 Reset with btn_i=1 held -> all outputs 0 during and on the first edge after reset; then press_o at the 6th edge after release of reset.
REQ-030 btn_i 0->1 held -> level_o=1 and press_o=1 for one cycle exactly at the 6th sampling edge.
REQ-031 btn_i high for 3 edges then low (bounce) -> level_o, press_o and release_o stay 0; a following clean 6-edge high is accepted normally.
REQ-032 Press held 25 cycles with a 2-cycle low glitch at cycle 5 after press_o -> exactly one long_o, at the 10th edge after press_o; no release_o.
REQ-033 Release after 4 cycles high -> release_o at the 6th edge after the fall, no long_o; an immediate re-press counts long_o from the new press_o.
REQ-034 system1000_rst asserted mid-CHECK_HIGH and again while level_o=1 -> FSM at STABLE_LOW, counters 0, no press_o/release_o pulse.
